// File: rtl/wdt_cfg_writer.sv
// Watchdog register front-end: shadows, ordered command FIFO, timeout irq.
// Define WDT_IRQ_LATCH_EN for a sticky, W1C-cleared irq; default is a registered level.
module wdt_cfg_writer #(
  parameter int CMD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_err,
  input  logic        rd_valid,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_resp,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_sel,
  output logic [31:0] cmd_data,
  input  logic        wto_in,
  output logic        irq
);

  localparam int AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(CMD_DEPTH);

  logic [33:0]   mem [CMD_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nx;
  logic          ready_q;
  logic          en_q;
  logic [31:0]   tocnt_q;
  logic          irq_q;

  logic [2:0]  widx;
  logic        wr_fire;
  logic        push;
  logic        pop;
  logic        clr;
  logic        full;
  logic [31:0] cmd_pay;
  logic [3:0]  occ;
  logic [31:0] status;
  logic [31:0] rd_mux;
  logic        unused;

  assign widx    = wr_addr[4:2];
  assign wr_fire = wr_valid & ready_q;
  assign push    = wr_fire & (widx <= 3'd2);
  assign pop     = cmd_valid & cmd_ready;
  assign clr     = wr_fire & (widx == 3'd3) & wr_data[0];
  assign full    = (cnt == FULL_CNT);
  assign cmd_pay = (widx == 3'd2) ? wr_data : {31'b0, wr_data[0]};
  assign unused  = ^{wr_addr[1:0], rd_addr[1:0]};

  assign wr_ready  = ready_q;
  assign irq       = irq_q;
  assign cmd_valid = (cnt != '0);
  assign cmd_sel   = cmd_valid ? mem[rp][33:32] : 2'b0;
  assign cmd_data  = cmd_valid ? mem[rp][31:0] : 32'b0;

  always_comb begin
    cnt_nx = cnt;
    unique case ({push, pop})
      2'b10:   cnt_nx = cnt + 1'b1;
      2'b01:   cnt_nx = cnt - 1'b1;
      default: cnt_nx = cnt;
    endcase
  end

  always_comb begin
    occ = 4'hF;
    if (32'(cnt) < 32'd15)
      occ = 4'(cnt);
  end

  assign status = {24'b0, occ, 1'b0, ~cmd_valid, full, irq_q};

  always_comb begin
    rd_mux = 32'b0;
    unique case (1'b1)
      (rd_addr[4:2] == 3'd0): rd_mux = {31'b0, en_q};
      (rd_addr[4:2] == 3'd2): rd_mux = tocnt_q;
      (rd_addr[4:2] == 3'd3): rd_mux = status;
      default:                rd_mux = 32'b0;
    endcase
  end

  // Storage is not reset; pointer/count reset is what discards entries.
  always_ff @(posedge clk) begin
    if (push)
      mem[wp] <= {widx[1:0], cmd_pay};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      tocnt_q <= 32'b0;
      rd_data <= 32'b0;
      rd_resp <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      cnt     <= cnt_nx;
      ready_q <= (cnt_nx != FULL_CNT);
      rd_resp <= rd_valid;
      rd_data <= rd_valid ? rd_mux : 32'b0;
      wr_err  <= wr_fire & wr_addr[4];
      if (wr_fire && widx == 3'd0)
        en_q <= wr_data[0];
      if (wr_fire && widx == 3'd2)
        tocnt_q <= wr_data;
    end
  end

`ifdef WDT_IRQ_LATCH_EN
  logic wto_q;

  // Set has priority over a coincident W1C clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wto_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      wto_q <= wto_in;
      if (wto_in && !wto_q)
        irq_q <= 1'b1;
      else if (clr)
        irq_q <= 1'b0;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr;

  always_ff @(posedge clk) begin
    if (!rst)
      irq_q <= 1'b0;
    else
      irq_q <= wto_in;
  end
`endif

endmodule

// File: doc/wdt_cfg_writer.md
# wdt_cfg_writer

Bus-side register front-end for the watchdog timer. It accepts CPU register writes and reads on a simple valid/ready port and keeps shadow copies of the enable and threshold registers. Each configuration write becomes a command on an ordered valid/ready channel, buffered in a small FIFO. That channel feeds the crossing that produces the watchdog's `WDEN`/`WDLIVE`/`WTOCNT` values and their `*_RVALID` strobes. The block also turns the synchronized watchdog timeout level into a CPU interrupt.

## Interface
Parameters:
- `CMD_DEPTH`, default 4: command FIFO depth. Must be a power of 2, ≥2.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`.
- `wr_addr`  in  5  byte offset; bits [1:0] are ignored.
- `wr_data`  in  32  write data.
- `wr_err`  out  1  one-cycle pulse: the accepted write targeted an unmapped offset.
- `rd_valid`  in  1  read request; always accepted.
- `rd_addr`  in  5  byte offset.
- `rd_data`  out  32  read data.
- `rd_resp`  out  1  one-cycle pulse: `rd_data` is valid.
- `cmd_valid`  out  1  FIFO head is valid.
- `cmd_ready`  in  1  downstream consumes the head.
- `cmd_sel`  out  2  0=WDEN, 1=WDLIVE, 2=WTOCNT.
- `cmd_data`  out  32  command payload.
- `wto_in`  in  1  timeout level, already synchronized to `clk`.
- `irq`  out  1  interrupt to the CPU.

## Operation
- Register map:
  - 0x00 WDEN: bit0 is the enable.
  - 0x04 WDLIVE: bit0 is the kick; reads return 0.
  - 0x08 WTOCNT: 32-bit threshold.
  - 0x0C STATUS:
    - bit0 irq state.
    - bit1 FIFO full.
    - bit2 FIFO empty.
    - bits[7:4] FIFO occupancy (saturating at 15).
    - Other bits read 0.
  - Offsets 0x10–0x1F are unmapped.
- Writes to 0x00, 0x04 and 0x08:
  - Enqueue one entry `{sel, data}`. For WDEN and WDLIVE, data is `{31'b0, wr_data[0]}`. For WTOCNT, data is the full 32-bit `wr_data`.
  - The WDEN and WTOCNT shadows update on acceptance, not when the entry drains.
- Writes to 0x0C: writing 1 to bit0 clears the irq latch. Nothing is enqueued.
- Writes to an unmapped offset: accepted only when `wr_ready` is high, no state changes, and `wr_err` pulses.
- `wr_ready = !full` for every offset. This keeps acceptance address-independent.
- Reads return the shadow values or STATUS. Unmapped reads return 0 and do not raise `wr_err`.
- FIFO behaviour:
  - Strict order, no coalescing.
  - Push and pop in the same cycle leaves occupancy unchanged. This is legal when not full, and also when full only if no push is accepted (full blocks the push).
  - Pointers wrap modulo `CMD_DEPTH`.
  - When empty, `cmd_sel` and `cmd_data` drive 0.
- Downstream handshake:
  - Once `cmd_valid` is high, the head stays stable until `cmd_ready` is seen.
  - `cmd_valid` never depends combinationally on `cmd_ready`.

## Timing
- Reset (`rst`=0 at a rising edge) forces every output to 0:
  - `wr_ready` is 0 during reset and 1 on the first cycle after reset.
  - Shadows are cleared, the FIFO is emptied and the irq latch is cleared.
  - Reset mid-operation discards queued commands.
- A write accepted at edge N has `cmd_valid` high from N+1 if the FIFO was empty. There is no bypass.
- Read latency is 1: a request at edge N gives `rd_data`/`rd_resp` during N→N+1.
- A read in the same cycle as an accepted write to the same register returns the pre-write value.
- `wr_err` is asserted in the cycle after acceptance.
- Full boundary:
  - The push that fills the FIFO drops `wr_ready` on the next cycle.
  - A pop in the cycle where the FIFO is full raises `wr_ready` on the next cycle.
- irq set and clear in the same cycle: set wins.

## Configuration
- `WDT_IRQ_LATCH_EN` defined:
  - `irq` is sticky. It sets on a rising edge of `wto_in`, detected with a registered copy, so it appears 1 cycle after the edge.
  - It clears only by writing 1 to STATUS bit0.
- `WDT_IRQ_LATCH_EN` undefined:
  - `irq` is `wto_in` registered one cycle.
  - STATUS bit0 mirrors it, and the W1C write has no effect beyond its `wr_err`-free acceptance.

## Test plan
- Reset, then write 0x08=0x0000_0100 and 0x00=1 with `cmd_ready`=1: entries `{2,0x100}` then `{0,1}` emerge in order, each one cycle after acceptance. Reading 0x08 returns 0x100.
- Hold `cmd_ready`=0 and write 0x04 five times with `CMD_DEPTH`=4:
  - `wr_ready` falls after the 4th write; STATUS reads 0x0000_0042.
  - Pulse `cmd_ready` once: `wr_ready` returns and the 5th write is accepted.
- Write to 0x14: `wr_err` pulses once, nothing is enqueued, and a read of 0x14 returns 0.
- With `WDT_IRQ_LATCH_EN`, pulse `wto_in` high for 3 cycles: `irq` stays 1 afterwards.
  - Write 0x0C=1: `irq` becomes 0.
  - Repeat with the W1C write coinciding with a new `wto_in` rise: `irq` stays 1.
- Without the macro: `irq` tracks `wto_in` with 1-cycle delay.
- Assert `rst`=0 with 3 entries queued and `cmd_ready`=0: the next cycle shows `cmd_valid`=0, `irq`=0 and shadows 0, and STATUS reads 0x4 after reset.
